wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Write-back end of the MEM/WB pipeline latch. Consumes the latched outputs (wsel_l, regsrc_l, regen_l, porto_l, dmemload_l) and selects the write-back word.
- Commits that word to a 32x32 register file and serves the two ID-stage read ports.
- Tracks retirement and halt status for the system/testbench.

Parameters:
- NREGS, 32, number of architectural registers; index width is log2(NREGS) = 5, matching regbits_t.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- wb_valid  input  1  latched MEM/WB slot holds a real instruction; low for a bubble.
- wsel_l  input  5  destination register index.
- regen_l  input  1  register write enable from control.
- regsrc_l  input  2  write-back source select.
- porto_l  input  32  ALU result.
- dmemload_l  input  32  load data.
- npc_l  input  32  PC+4, used for link writes.
- imm_l  input  32  upper-immediate value, already shifted.
- halt_l  input  1  latched instruction is HALT.
- rsel1  input  5  read port 1 index.
- rsel2  input  5  read port 2 index.
- rdat1  output  32  read port 1 data.
- rdat2  output  32  read port 2 data.
- wb_wen  output  1  registered: a write committed last cycle.
- wb_wsel  output  5  registered index of that write, for forwarding.
- wb_wdat  output  32  registered data of that write.
- retired  output  CNT_W  count of retired valid instructions.
- halted  output  1  sticky halt flag.

Behaviour:
- Source mux (combinational), regsrc_l:
  - 00 → porto_l
  - 01 → dmemload_l
  - 10 → npc_l
  - 11 → imm_l
- Commit condition: wb_valid & regen_l & (wsel_l != 0) & ~halted. Register file updates on the rising CLK edge; zero latency into the array.
- Register 0: reads always return 0; writes to it are dropped silently.
- Read ports: combinational from the array.
- Write-through: when WB_BYPASS_EN is defined, a read of the index being committed in the same cycle returns the new value (see Optional Feature).
- Registered commit echo: wb_wen, wb_wsel and wb_wdat mirror the previous cycle's commit. wb_wen = 0 when no commit occurred; wb_wsel and wb_wdat then hold their last values.
- retired:
  - Increments by 1 on each edge where wb_valid & ~halted.
  - Counts non-writing instructions (stores, branches) too.
  - Wraps modulo 2^CNT_W with no saturation.
- Halt FSM, two states, RUN and HALTED:
  - RUN → HALTED on an edge where wb_valid & halt_l.
  - The HALT itself increments retired.
  - HALTED is absorbing until RST.
  - In HALTED: no commits, no counting, wb_wen = 0. Reads remain functional.
- halted = (state == HALTED).
- Bubble (wb_valid = 0): no commit, no count, no state change, regardless of other inputs.
- Reset (asynchronous, any cycle including mid-commit):
  - All 32 registers ← 0.
  - retired ← 0.
  - state ← RUN.
  - wb_wen ← 0, wb_wsel ← 0, wb_wdat ← 0.
  - A commit coinciding with reset assertion is lost.
- Simultaneous halt_l & regen_l on one valid slot: the commit is performed (state is still RUN at that edge), then the FSM enters HALTED.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: rdatN = wdat when commit & (rselN == wsel_l), else array[rselN]. rsel == 0 still returns 0.
- Undefined: rdatN = array[rselN]. The new value is visible the cycle after commit, and the hazard unit must cover that extra cycle.

Decomposition:
- cpu_types_pkg gains:
  - regsrc_t, a 2-bit enum: WB_ALU = 2'b00, WB_MEM = 2'b01, WB_LINK = 2'b10, WB_LUI = 2'b11.
  - wbstate_t enum: RUN, HALTED.
- wb_stage reuses word_t and regbits_t from cpu_types_pkg.
- One sub-module, wb_register_file:
  - Array, two read ports, one write port, reg-0 rule, optional bypass.
  - wb_stage keeps the mux, commit logic, echo registers, counter and FSM.

Test Plan:
- Reset mid-run: write R5 = 0xDEADBEEF, assert RST for 1 cycle → rdat1 for R5 = 0, retired = 0, halted = 0, wb_wen = 0.
- Source mux, four valid writes to R1–R4 with regsrc 00/01/10/11 and porto = 0x11, dmemload = 0x22, npc = 0x33, imm = 0x44000000 → R1–R4 read 0x11, 0x22, 0x33, 0x44000000; retired = 4.
- Register 0: valid regen write wsel = 0, porto = 0xFFFFFFFF → rdat1 (rsel1 = 0) = 0, wb_wen = 0 next cycle, retired increments.
- Bubble and no-write: wb_valid = 0 with regen = 1 → no change anywhere. wb_valid = 1, regen = 0 → retired increments, registers unchanged.
- Bypass: same-cycle write R7 = 0x1234 with rsel2 = 7 → rdat2 = 0x1234 that cycle if WB_BYPASS_EN is defined, old value if undefined; 0x1234 the next cycle in both builds.
- Halt: valid HALT with regen writing R9 = 0x99 → R9 = 0x99, halted = 1, retired + 1. Subsequent valid writes to R9 are ignored and retired stays frozen until RST.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, register index, write-back source
// select and the write-back halt state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  // Write-back source select driven by the MEM/WB latch.
  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_LINK = 2'b10,
    WB_LUI  = 2'b11
  } regsrc_t;

  // Retirement state: running, or stopped by a HALT until reset.
  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } wbstate_t;

endpackage

// File: rtl/wb_register_file.sv
// 32x32 architectural register file: one write port, two combinational
// read ports, register 0 hard-wired to zero.
// Macro WB_BYPASS_EN: a read of the index being written this cycle
// returns the incoming write data instead of the stored value.
module wb_register_file
  import cpu_types_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        wen_i,
  input  logic [4:0]  wsel_i,
  input  logic [31:0] wdat_i,
  input  logic [4:0]  rsel1_i,
  input  logic [4:0]  rsel2_i,
  output logic [31:0] rdat1_o,
  output logic [31:0] rdat2_o
);

  word_t regs_q [NREGS];

  // Register array: cleared on reset, written on the edge a commit is presented.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= 32'h0000_0000;
      end
    end else if (wen_i && (wsel_i != 5'd0)) begin
      regs_q[wsel_i] <= wdat_i;
    end
  end

  // Read port 1: zero register, optional write-through, else stored value.
  always_comb begin
    rdat1_o = 32'h0000_0000;
    if (rsel1_i == 5'd0) begin
      rdat1_o = 32'h0000_0000;
    end
`ifdef WB_BYPASS_EN
    else if (wen_i && (rsel1_i == wsel_i)) begin
      rdat1_o = wdat_i;
    end
`endif
    else begin
      rdat1_o = regs_q[rsel1_i];
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    rdat2_o = 32'h0000_0000;
    if (rsel2_i == 5'd0) begin
      rdat2_o = 32'h0000_0000;
    end
`ifdef WB_BYPASS_EN
    else if (wen_i && (rsel2_i == wsel_i)) begin
      rdat2_o = wdat_i;
    end
`endif
    else begin
      rdat2_o = regs_q[rsel2_i];
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: selects the write-back word from the MEM/WB latch,
// commits it to the register file, echoes the commit for forwarding,
// counts retired instructions and tracks a sticky halt.
// Macro WB_BYPASS_EN (passed through to wb_register_file) enables
// same-cycle write-through on the read ports.
module wb_stage
  import cpu_types_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wb_valid,
  input  logic [4:0]       wsel_l,
  input  logic             regen_l,
  input  logic [1:0]       regsrc_l,
  input  logic [31:0]      porto_l,
  input  logic [31:0]      dmemload_l,
  input  logic [31:0]      npc_l,
  input  logic [31:0]      imm_l,
  input  logic             halt_l,
  input  logic [4:0]       rsel1,
  input  logic [4:0]       rsel2,
  output logic [31:0]      rdat1,
  output logic [31:0]      rdat2,
  output logic             wb_wen,
  output logic [4:0]       wb_wsel,
  output logic [31:0]      wb_wdat,
  output logic [CNT_W-1:0] retired,
  output logic             halted
);

  wbstate_t         state_q, state_d;
  logic             wen_q;
  regbits_t         wsel_q;
  word_t            wdat_q;
  logic [CNT_W-1:0] retired_q, retired_d;
  word_t            wdat_s;
  logic             commit_s;
  logic             live_s;

  // Source mux: pick the write-back word from the latched operands.
  always_comb begin
    wdat_s = 32'h0000_0000;
    case (regsrc_t'(regsrc_l))
      WB_ALU:  wdat_s = porto_l;
      WB_MEM:  wdat_s = dmemload_l;
      WB_LINK: wdat_s = npc_l;
      WB_LUI:  wdat_s = imm_l;
      default: wdat_s = porto_l;
    endcase
  end

  // A real instruction while running retires; it commits if it writes a non-zero register.
  always_comb begin
    live_s   = wb_valid && (state_q == RUN);
    commit_s = live_s && regen_l && (wsel_l != 5'd0);
  end

  // Halt FSM next state and retire counter next value.
  always_comb begin
    state_d   = state_q;
    retired_d = retired_q;
    case (state_q)
      RUN: begin
        if (wb_valid) begin
          retired_d = retired_q + CNT_W'(1);
          if (halt_l) begin
            state_d = HALTED;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State, counter and commit-echo registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= RUN;
      retired_q <= {CNT_W{1'b0}};
      wen_q     <= 1'b0;
      wsel_q    <= 5'd0;
      wdat_q    <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      wen_q     <= commit_s;
      if (commit_s) begin
        wsel_q <= wsel_l;
        wdat_q <= wdat_s;
      end
    end
  end

  wb_register_file #(
    .NREGS (NREGS)
  ) u_rf (
    .CLK     (CLK),
    .RST     (RST),
    .wen_i   (commit_s),
    .wsel_i  (wsel_l),
    .wdat_i  (wdat_s),
    .rsel1_i (rsel1),
    .rsel2_i (rsel2),
    .rdat1_o (rdat1),
    .rdat2_o (rdat2)
  );

  assign wb_wen  = wen_q;
  assign wb_wsel = wsel_q;
  assign wb_wdat = wdat_q;
  assign retired = retired_q;
  assign halted  = (state_q == HALTED);

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle
// against an architectural model kept in the bench.
module tb_wb_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wsel_l = 5'd0;
  logic        regen_l = 1'b0;
  logic [1:0]  regsrc_l = 2'd0;
  logic [31:0] porto_l = 32'h0;
  logic [31:0] dmemload_l = 32'h0;
  logic [31:0] npc_l = 32'h0;
  logic [31:0] imm_l = 32'h0;
  logic        halt_l = 1'b0;
  logic [4:0]  rsel1 = 5'd0;
  logic [4:0]  rsel2 = 5'd0;
  logic [31:0] rdat1, rdat2, wb_wdat, retired;
  logic [4:0]  wb_wsel;
  logic        wb_wen, halted;

  int checks = 0;
  int errors = 0;

  wb_stage dut (
    .CLK(CLK), .RST(RST), .wb_valid(wb_valid), .wsel_l(wsel_l),
    .regen_l(regen_l), .regsrc_l(regsrc_l), .porto_l(porto_l),
    .dmemload_l(dmemload_l), .npc_l(npc_l), .imm_l(imm_l),
    .halt_l(halt_l), .rsel1(rsel1), .rsel2(rsel2), .rdat1(rdat1),
    .rdat2(rdat2), .wb_wen(wb_wen), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
    .retired(retired), .halted(halted)
  );

  always #5 CLK = ~CLK;

  // ---------------- architectural model ----------------
  logic [31:0] m_regs [32];
  logic [31:0] m_retired;
  logic        m_halted;
  logic        m_wen;
  logic [4:0]  m_wsel;
  logic [31:0] m_wdat;

  function automatic logic [31:0] src_word();
    logic [31:0] srcs [4];
    srcs[0] = porto_l;
    srcs[1] = dmemload_l;
    srcs[2] = npc_l;
    srcs[3] = imm_l;
    return srcs[regsrc_l];
  endfunction

  function automatic logic writes_now();
    return wb_valid && regen_l && (wsel_l != 5'd0) && !m_halted;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] sel);
    if (sel == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (writes_now() && sel == wsel_l) return src_word();
`endif
    return m_regs[sel];
  endfunction

  // Model state: updated on the same edges as the design.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'h0;
      m_retired <= 32'h0;
      m_halted  <= 1'b0;
      m_wen     <= 1'b0;
      m_wsel    <= 5'd0;
      m_wdat    <= 32'h0;
    end else begin
      m_wen <= writes_now();
      if (writes_now()) begin
        m_regs[wsel_l] <= src_word();
        m_wsel <= wsel_l;
        m_wdat <= src_word();
      end
      if (wb_valid && !m_halted) begin
        m_retired <= m_retired + 32'd1;
        if (halt_l) m_halted <= 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    chk("rdat1",   rdat1,          exp_read(rsel1));
    chk("rdat2",   rdat2,          exp_read(rsel2));
    chk("wb_wen",  {31'd0, wb_wen}, {31'd0, m_wen});
    chk("wb_wsel", {27'd0, wb_wsel}, {27'd0, m_wsel});
    chk("wb_wdat", wb_wdat,        m_wdat);
    chk("retired", retired,        m_retired);
    chk("halted",  {31'd0, halted}, {31'd0, m_halted});
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic look();
    @(negedge CLK);
    #1;
  endtask

  task automatic idle();
    wb_valid = 1'b0;
    regen_l  = 1'b0;
    halt_l   = 1'b0;
  endtask

  task automatic drv(input logic v, input logic re, input logic [4:0] ws,
                     input logic [1:0] rs, input logic [31:0] po, input logic h);
    wb_valid = v;
    regen_l  = re;
    wsel_l   = ws;
    regsrc_l = rs;
    porto_l  = po;
    halt_l   = h;
  endtask

  initial begin
    #1 RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // Reset mid-run after writing R5.
    drv(1'b1, 1'b1, 5'd5, 2'd0, 32'hDEADBEEF, 1'b0); tick();
    idle(); rsel1 = 5'd5; look();
    chk("r5_written", rdat1, 32'hDEADBEEF);
    RST = 1'b1; tick(); RST = 1'b0;
    look();
    chk("r5_after_rst", rdat1, 32'h0);
    chk("retired_after_rst", retired, 32'd0);
    chk("halted_after_rst", {31'd0, halted}, 32'd0);
    chk("wen_after_rst", {31'd0, wb_wen}, 32'd0);
    tick();

    // Source mux: R1..R4 from each source.
    dmemload_l = 32'h22; npc_l = 32'h33; imm_l = 32'h4400_0000;
    for (int i = 1; i <= 4; i++) begin
      drv(1'b1, 1'b1, 5'(i), 2'(i - 1), 32'h11, 1'b0); tick();
    end
    idle(); rsel1 = 5'd1; rsel2 = 5'd2; look();
    chk("mux_alu", rdat1, 32'h11);
    chk("mux_mem", rdat2, 32'h22);
    tick(); rsel1 = 5'd3; rsel2 = 5'd4; look();
    chk("mux_link", rdat1, 32'h33);
    chk("mux_lui", rdat2, 32'h4400_0000);
    chk("retired_4", retired, 32'd4);
    tick();

    // Register 0 write is dropped but retires.
    drv(1'b1, 1'b1, 5'd0, 2'd0, 32'hFFFF_FFFF, 1'b0); rsel1 = 5'd0; tick();
    idle(); look();
    chk("r0_read", rdat1, 32'h0);
    chk("r0_no_wen", {31'd0, wb_wen}, 32'd0);
    chk("retired_5", retired, 32'd5);
    tick();

    // Bubble with regen set: nothing changes.
    drv(1'b0, 1'b1, 5'd1, 2'd0, 32'hAAAA, 1'b0); tick();
    idle(); rsel1 = 5'd1; look();
    chk("bubble_r1", rdat1, 32'h11);
    chk("bubble_retired", retired, 32'd5);
    chk("bubble_wen", {31'd0, wb_wen}, 32'd0);
    tick();
    // Valid non-writing instruction retires only.
    drv(1'b1, 1'b0, 5'd1, 2'd0, 32'hBBBB, 1'b0); tick();
    idle(); look();
    chk("nowrite_r1", rdat1, 32'h11);
    chk("retired_6", retired, 32'd6);
    tick();

    // Same-cycle read of R7 while it is written.
    drv(1'b1, 1'b1, 5'd7, 2'd0, 32'h1234, 1'b0); rsel2 = 5'd7; look();
`ifdef WB_BYPASS_EN
    chk("bypass_same", rdat2, 32'h1234);
`else
    chk("bypass_same", rdat2, 32'h0);
`endif
    tick(); idle(); look();
    chk("bypass_next", rdat2, 32'h1234);
    chk("retired_7", retired, 32'd7);
    tick();

    // HALT that also writes R9, then frozen.
    drv(1'b1, 1'b1, 5'd9, 2'd0, 32'h99, 1'b1); tick();
    idle(); rsel1 = 5'd9; look();
    chk("halt_r9", rdat1, 32'h99);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_retired", retired, 32'd8);
    tick();
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1'b1, 5'd9, 2'd0, 32'h55, 1'b0); tick(); look();
      chk("frozen_r9", rdat1, 32'h99);
      chk("frozen_retired", retired, 32'd8);
      chk("frozen_wen", {31'd0, wb_wen}, 32'd0);
      tick();
    end

    // Async reset between edges, then random traffic.
    idle();
    RST = 1'b1; #2; RST = 1'b0;
    for (int n = 0; n < 500; n++) begin
      wb_valid   = ($urandom_range(0, 3) != 0);
      regen_l    = ($urandom_range(0, 3) != 0);
      wsel_l     = 5'($urandom_range(0, 31));
      regsrc_l   = 2'($urandom_range(0, 3));
      porto_l    = $urandom;
      dmemload_l = $urandom;
      npc_l      = $urandom;
      imm_l      = $urandom;
      halt_l     = ($urandom_range(0, 60) == 0);
      rsel1      = ($urandom_range(0, 2) == 0) ? wsel_l : 5'($urandom_range(0, 31));
      rsel2      = ($urandom_range(0, 2) == 0) ? wsel_l : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 40) == 0) begin
        RST = 1'b1; #2; RST = 1'b0;
      end
      tick();
    end

    idle();
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
